// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES MixColumns sequencer.
//   AES_POLY   - low byte of the GF(2^8) reduction polynomial 0x11B
//   BYTE_W / COL_W / STATE_W / NUM_COLS - data geometry
//   xtime()    - multiply a byte by {02} in GF(2^8)
//   mix_state_e - sequencer FSM states (IDLE/MIX/DONE)
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int BYTE_W   = 8;
  localparam int COL_W    = 32;
  localparam int STATE_W  = 128;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// aes_mixcol_col: combinational mixer for one 32-bit AES state column.
//   col_in  [31:0] - column, byte a0 in [31:24] .. a3 in [7:0]
//   inv            - select InvMixColumns (only honoured with AES_MIXCOL_INV_EN)
//   col_out [31:0] - mixed column, same byte ordering
// Build option: define AES_MIXCOL_INV_EN to synthesize the inverse transform.
module aes_mixcol_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             inv,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a  [NUM_COLS];
  logic [BYTE_W-1:0] a2 [NUM_COLS];
  logic [COL_W-1:0]  fwd_col;

  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) begin
      a[i]  = col_in[COL_W-1-BYTE_W*i -: BYTE_W];
      a2[i] = xtime(a[i]);
    end
  end

  // r_i = 2*a_i ^ 3*a_{i+1} ^ a_{i+2} ^ a_{i+3}, indices mod 4
  always_comb begin
    fwd_col = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      fwd_col[COL_W-1-BYTE_W*i -: BYTE_W] = a2[i] ^ a2[2'(i+1)] ^ a[2'(i+1)]
                                           ^ a[2'(i+2)] ^ a[2'(i+3)];
    end
  end

`ifdef AES_MIXCOL_INV_EN
  logic [BYTE_W-1:0] a4 [NUM_COLS];
  logic [BYTE_W-1:0] a8 [NUM_COLS];
  logic [COL_W-1:0]  inv_col;

  // Inverse coefficients from chained xtime:
  // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
  always_comb begin
    inv_col = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      a4[i] = xtime(a2[i]);
      a8[i] = xtime(a4[i]);
    end
    for (int i = 0; i < NUM_COLS; i++) begin
      inv_col[COL_W-1-BYTE_W*i -: BYTE_W] =
          (a8[i] ^ a4[i] ^ a2[i])
        ^ (a8[2'(i+1)] ^ a2[2'(i+1)] ^ a[2'(i+1)])
        ^ (a8[2'(i+2)] ^ a4[2'(i+2)] ^ a[2'(i+2)])
        ^ (a8[2'(i+3)] ^ a[2'(i+3)]);
    end
  end

  assign col_out = inv ? inv_col : fwd_col;
`else
  // Forward-only build: inv is accepted for port compatibility and has no effect.
  assign col_out = fwd_col ^ {COL_W{inv & 1'b0}};
`endif

endmodule

// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq: column-serial AES MixColumns sequencer.
// Captures a 128-bit state, mixes COLS_PER_CYCLE columns per cycle through
// shared aes_mixcol_col units, and holds the result on an output handshake.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - input handshake; in_state, in_bypass, in_inv sampled at accept
//   out_valid/out_ready - output handshake; out_state holds the result
//   busy                - high while in MIX or DONE
//   state_dbg           - current FSM state (mix_state_e encoding)
// Parameter COLS_PER_CYCLE: 1, 2 or 4.
// Build option: AES_MIXCOL_INV_EN enables the InvMixColumns path selected by in_inv.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE, and
// out_state is held constant until the transfer. Inputs outside IDLE are ignored.
module aes_mixcol_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_bypass,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("aes_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

  mix_state_e         state_q, state_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [STATE_W-1:0] res_q, res_d;
  logic [1:0]         col_cnt_q, col_cnt_d;
  logic               bypass_q, bypass_d;
  logic               inv_q, inv_d;

  logic [1:0]       slot    [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_out [COLS_PER_CYCLE];

  // Unit g handles column col_cnt+g; column c lives in bits [127-32c -: 32].
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign slot[g]   = col_cnt_q + 2'(g);
    assign mix_in[g] = data_q[COL_W*(NUM_COLS-1-int'(slot[g])) +: COL_W];

    aes_mixcol_col u_col (
      .col_in  (mix_in[g]),
      .inv     (inv_q),
      .col_out (mix_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    res_d     = res_q;
    col_cnt_d = col_cnt_q;
    bypass_d  = bypass_q;
    inv_d     = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d    = in_state;
          bypass_d  = in_bypass;
          inv_d     = in_inv;
          col_cnt_d = '0;
          res_d     = '0;
          state_d   = ST_MIX;
        end
      end
      ST_MIX: begin
        // Bypass spends a single MIX cycle copying the state so that its
        // output timing matches a one-group mix.
        if (bypass_q) begin
          res_d   = data_q;
          state_d = ST_DONE;
        end else begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            res_d[COL_W*(NUM_COLS-1-int'(slot[g])) +: COL_W] = mix_out[g];
          end
          col_cnt_d = col_cnt_q + CNT_STEP;
          if (col_cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      res_q     <= '0;
      col_cnt_q <= '0;
      bypass_q  <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      res_q     <= res_d;
      col_cnt_q <= col_cnt_d;
      bypass_q  <= bypass_d;
      inv_q     <= inv_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MIX) || (state_q == ST_DONE);
  // The result register fills column by column; only show it once complete.
  assign out_state = out_valid ? res_q : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// tb_aes_mixcol_seq: runs three sequencers (COLS_PER_CYCLE = 1, 2, 4) in
// lockstep on shared inputs and checks them against a GF(2^8) matrix model.
module tb_aes_mixcol_seq;

  localparam int ND = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         in_inv;
  logic         out_ready;

  logic         in_ready_w  [ND];
  logic         out_valid_w [ND];
  logic         busy_w      [ND];
  logic [127:0] out_state_w [ND];
  logic [1:0]   state_dbg_w [ND];

  int lat_exp [ND] = '{4, 2, 1};

  int n_total = 0;
  int n_bad   = 0;

  logic [127:0] exp_q[$];

  aes_mixcol_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_state(in_state), .in_bypass(in_bypass), .in_inv(in_inv),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_state(out_state_w[0]),
    .busy(busy_w[0]), .state_dbg(state_dbg_w[0])
  );

  aes_mixcol_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_state(in_state), .in_bypass(in_bypass), .in_inv(in_inv),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_state(out_state_w[1]),
    .busy(busy_w[1]), .state_dbg(state_dbg_w[1])
  );

  aes_mixcol_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_state(in_state), .in_bypass(in_bypass), .in_inv(in_inv),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_state(out_state_w[2]),
    .busy(busy_w[2]), .state_dbg(state_dbg_w[2])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product per column; row r uses coef[(k - r) mod 4] on byte k.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   r;
    logic [127:0] o;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      for (int ri = 0; ri < 4; ri++) begin
        r = 8'h00;
        for (int k = 0; k < 4; k++) r = r ^ gf_mul(coef[(k - ri + 4) % 4], a[k]);
        o[127-32*c-8*ri -: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic inv_eff(input logic inv);
`ifdef AES_MIXCOL_INV_EN
    return inv;
`else
    return 1'b0 & inv;
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // One transaction through all three DUTs; hold = extra cycles of backpressure.
  task automatic run_txn(input logic [127:0] st, input logic byp, input logic inv,
                         input logic [127:0] exp, input int hold);
    int           lat  [ND];
    logic [127:0] held [ND];
    logic [127:0] want;
    logic         rdy_low;
    logic         stable;
    exp_q.push_back(exp);
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("in_ready_idle", in_ready_w[d], 1'b1);
    in_valid  = 1'b1;
    in_state  = st;
    in_bypass = byp;
    in_inv    = inv;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_state  = rand128();
    in_bypass = 1'($urandom_range(0, 1));
    in_inv    = 1'($urandom_range(0, 1));
    for (int d = 0; d < ND; d++) lat[d] = 0;
    rdy_low = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        if (lat[d] == 0 && out_valid_w[d]) lat[d] = k;
        if (in_ready_w[d] !== 1'b0 || busy_w[d] !== 1'b1) rdy_low = 1'b0;
      end
      // Competing input traffic while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_state = rand128();
    end
    in_valid = 1'b0;
    check("in_ready_low_busy", rdy_low, 1'b1);
    want = exp_q.pop_front();
    for (int d = 0; d < ND; d++) begin
      check("latency", lat[d], byp ? 1 : lat_exp[d]);
      check("result", out_state_w[d], want);
      held[d] = out_state_w[d];
    end
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_state = rand128();
      for (int d = 0; d < ND; d++) begin
        if (out_valid_w[d] !== 1'b1 || out_state_w[d] !== held[d] || in_ready_w[d] !== 1'b0)
          stable = 1'b0;
      end
    end
    check("backpressure_hold", stable, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check("out_valid_drop", out_valid_w[d], 1'b0);
      check("in_ready_back", in_ready_w[d], 1'b1);
    end
  endtask

  task automatic reset_mid_mix();
    @(negedge clk);
    in_valid  = 1'b1;
    in_state  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    in_bypass = 1'b0;
    in_inv    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mix_busy_before_rst", busy_w[0], 1'b1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_out_valid", out_valid_w[d], 1'b0);
      check("rst_out_state", out_state_w[d], '0);
      check("rst_busy", busy_w[d], 1'b0);
      check("rst_in_ready", in_ready_w[d], 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] st;
    logic         byp;
    logic         inv;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_bypass = 1'b0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    for (int d = 0; d < ND; d++) begin
      check("reset_in_ready", in_ready_w[d], 1'b1);
      check("reset_out_valid", out_valid_w[d], 1'b0);
      check("reset_out_state", out_state_w[d], '0);
      check("reset_busy", busy_w[d], 1'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 column example
    run_txn(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1);
    // Bypass returns the state untouched
    run_txn(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b0,
            128'h00112233_44556677_8899aabb_ccddeeff, 1);
    // Long backpressure
    run_txn(128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0, 1'b0,
            128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 10);
    // Reset in the middle of MIX, then a fresh vector
    reset_mid_mix();
    run_txn(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0);
    // Inverse select
`ifdef AES_MIXCOL_INV_EN
    run_txn(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 1'b1,
            128'hdb135345_f20a225c_01010101_c6c6c6c6, 2);
`else
    run_txn(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 1'b1,
            ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0), 2);
`endif
    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      st  = rand128();
      byp = ($urandom_range(0, 3) == 0);
      inv = 1'($urandom_range(0, 1));
      run_txn(st, byp, inv, byp ? st : ref_mix(st, inv_eff(inv)), $urandom_range(0, 4));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
